// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage miniRV pipeline.
// Produces stall/flush/bubble controls for the PC and pipeline registers,
// EX operand-forwarding selects, a RAM-wait freeze FSM with a sticky
// timeout flag, and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter logic [1:0] LOAD_WSEL   = 2'b01,
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_wR,
    input  logic             ex_rf_we,
    input  logic [1:0]       ex_rf_wsel,
    input  logic [4:0]       mem_wR,
    input  logic             mem_rf_we,
    input  logic [4:0]       wb_wR,
    input  logic             wb_rf_we,
    input  logic             ex_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             freeze;
    logic             ex_is_load;
    logic             load_use;

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Forwarding select for one source operand, EX > MEM > WB; an EX load
    // hit selects the register file because the load-use stall covers it.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic       used,
        input logic       ex_we,
        input logic [4:0] ex_rd,
        input logic       ex_load,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (!used) begin
            return 2'b00;
        end
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == rs)) begin
            return ex_load ? 2'b00 : 2'b01;
        end
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            return 2'b10;
        end
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Hazard detection: freeze while RAM is pending, load-use on an EX load.
    always_comb begin
        freeze     = ((state_q == ST_RUN) & mem_req & ~mem_ready) |
                     ((state_q == ST_WAIT) & ~mem_ready);
        ex_is_load = ex_rf_we & (ex_rf_wsel == LOAD_WSEL);
        load_use   = ex_is_load & (ex_wR != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_wR)) |
                      (id_rs2_used & (id_rs2 == ex_wR)));
    end

    // Pipeline control outputs with priority reset > freeze > jump > load-use.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (cpu_rst) begin
            pc_stall = 1'b0;
        end else if (freeze) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_jump) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // Operand forwarding selects, independent of freeze, zeroed in reset.
    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (!cpu_rst) begin
            fwd_rs1_sel = fwd_select(id_rs1, id_rs1_used, ex_rf_we, ex_wR,
                                     ex_is_load, mem_rf_we, mem_wR,
                                     wb_rf_we, wb_wR);
            fwd_rs2_sel = fwd_select(id_rs2, id_rs2_used, ex_rf_we, ex_wR,
                                     ex_is_load, mem_rf_we, mem_wR,
                                     wb_rf_we, wb_wR);
        end
    end

    // RAM-wait FSM next state, wait counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_ONE;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != TIMEOUT_V) begin
                    wait_cnt_d = wait_cnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_err_d = mem_err_q |
                    ((state_d == ST_WAIT) && (wait_cnt_d == TIMEOUT_V));
    end

    // Event counters follow the stall and ID/EX flush outputs.
    always_comb begin
        stall_cnt_d = pc_stall    ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = id_ex_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State, wait counter, error flag and counters; async reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage miniRV pipeline. It watches the destination/write-enable fields carried by the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It drives the stall, flush and bubble controls of those registers and the PC, and the operand-forwarding selects in EX. A small FSM freezes the pipeline while a MEM-stage data-RAM access waits for `mem_ready`. Saturating counters record stall and flush cycles for trace/debug.

## Interface
- `LOAD_WSEL`, default 2'b01: `rf_wsel` encoding meaning "write-back from data RAM" (load).
- `MEM_TIMEOUT`, default 16: max `WAIT` cycles before `mem_err` sets.
- `CNT_W`, default 16: width of the performance counters.

- `cpu_clk`  in  1  pipeline clock, rising edge.
- `cpu_rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  ID instruction reads rs1 / rs2.
- `ex_wR`  in  5  EX-stage destination register.
- `ex_rf_we`  in  1  EX-stage write enable.
- `ex_rf_wsel`  in  2  EX-stage write-back select.
- `mem_wR`  in  5  MEM-stage destination register.
- `mem_rf_we`  in  1  MEM-stage write enable.
- `wb_wR`  in  5  WB-stage destination register.
- `wb_rf_we`  in  1  WB-stage write enable.
- `ex_jump`  in  1  EX resolved a taken branch, jal or jalr.
- `mem_req`  in  1  MEM stage performs a RAM load/store.
- `mem_ready`  in  1  RAM completes the access this cycle.
- `pc_stall`  out  1  hold the PC.
- `if_id_stall`  out  1  hold IF/ID.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_ex_stall`  out  1  hold ID/EX.
- `id_ex_flush`  out  1  load a NOP into ID/EX.
- `ex_mem_stall`  out  1  hold EX/MEM.
- `mem_wb_bubble`  out  1  load a NOP (rf_we=0) into MEM/WB.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  2 each  operand source: 00 register file, 01 EX result, 10 MEM result, 11 WB data.
- `mem_err`  out  1  sticky RAM-timeout flag.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- FSM states:
  - `RUN` → `WAIT` when `mem_req & ~mem_ready`.
  - `WAIT` → `RUN` on `mem_ready`.
  - `WAIT` also counts cycles in `wait_cnt`. When `wait_cnt` reaches `MEM_TIMEOUT`, `mem_err` sets and the FSM stays in `WAIT`.
- The freeze condition is `(state==RUN & mem_req & ~mem_ready) | (state==WAIT & ~mem_ready)`. While frozen:
  - `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_bubble` = 1.
  - All flushes = 0.
  - Jump and load-use detection are masked.
- Jump (not frozen, `ex_jump`): `if_id_flush` = `id_ex_flush` = 1. No stalls.
- Load-use (not frozen, no jump): asserted when `ex_rf_we`, `ex_rf_wsel==LOAD_WSEL`, `ex_wR!=0`, and a used ID source equals `ex_wR`. Response: `pc_stall` = `if_id_stall` = `id_ex_flush` = 1 for exactly one cycle. The next cycle re-evaluates with the load in MEM.
- Priority: freeze > jump > load-use. A jump coinciding with load-use flushes only; the ID instruction is wrong-path.
- Forwarding, per source, with priority EX > MEM > WB:
  - A stage hits when its `we=1`, its `wR!=0` and `wR==rs`.
  - An EX hit by a load gives 00, because a stall covers it.
  - If `rs_used=0`, the select is 00.
  - Forwarding is evaluated regardless of the freeze condition.
- `stall_cnt` increments on each cycle with `pc_stall=1`.
- `flush_cnt` increments on each cycle with `id_ex_flush=1`.
- Both counters saturate at all-ones.
- `mem_err` clears only on `cpu_rst`.

## Timing
- Control and forwarding outputs are combinational from the inputs and the FSM state. There is no added latency. They take effect at the next `cpu_clk` edge in the pipeline registers.
- FSM, `wait_cnt`, counters and `mem_err` update on the rising edge of `cpu_clk`.
- Reset (async, immediate):
  - State `RUN`, `wait_cnt`=0, `stall_cnt`=0, `flush_cnt`=0, `mem_err`=0.
  - While `cpu_rst`=1, all stall/flush/bubble outputs are forced to 0 and both `fwd_*_sel` to 00.
  - Reset during `WAIT` returns to `RUN`, abandoning the access.
- A single-cycle RAM access (`mem_ready` with `mem_req`) causes no stall and no state change.
- `mem_ready` without `mem_req` in `RUN` is ignored.

## Test plan
- Load-use: `ex_rf_we`=1, `ex_rf_wsel`=01, `ex_wR`=5, `id_rs1`=5, used → exactly 1 cycle of `pc_stall`/`if_id_stall`/`id_ex_flush`=1, then all 0. `stall_cnt` 0→1, `flush_cnt` 0→1.
- Forwarding priority: EX (ALU, `ex_wR`=3), MEM (`mem_wR`=3) and WB (`wb_wR`=3) all write, `id_rs2`=3 → `fwd_rs2_sel`=01. Remove EX → 10. Remove MEM → 11. Set `wb_wR`=`id_rs2`=0 → 00.
- Jump with load-use in the same cycle → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0.
- RAM wait: `mem_req`=1, `mem_ready`=0 for 3 cycles, then 1 → freeze outputs high for 3 cycles, FSM in `WAIT` for 2 cycles, release on the ready cycle. `stall_cnt`=3. A jump during the wait has no effect.
- Timeout: `mem_ready` held 0 for 20 cycles → `mem_err`=1 at cycle 16 of `WAIT` and remains 1 after `mem_ready`. Only `cpu_rst` clears it.
- Async reset mid-`WAIT` → outputs 0 immediately (no clock edge), counters 0, FSM in `RUN` after release.
